// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline sequencing / hazard controller.
//   state_e       : controller state (IDLE, RUN, MEM_WAIT, ERROR)
//   REG_ZERO      : register $zero; a load into it never creates a hazard
//   DEF_CNT_W     : default performance-counter width
//   state_active(): true in the states where the pipeline is allowed to move
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         DEF_CNT_W = 32;

    // RUN and MEM_WAIT both drive the pipeline; IDLE and ERROR freeze it.
    function automatic logic state_active(input state_e s);
        return (s == RUN) || (s == MEM_WAIT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the performance counters.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-low reset, clears the count
//   inc_i  : add one this cycle (ignored once the counter is full)
//   cnt_o  : current count, sticks at 2^W-1
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencing and hazard controller for the 5-stage MIPS pipeline.
// Resolves data-memory stalls, load-use stalls and branch/jump flushes (in
// that priority) into per-stage write/flush/bubble controls, gates the
// pipeline on start_i, traps hung memory transactions and keeps saturating
// performance counters.
//
// Parameters
//   CNT_W    : performance counter width
//   TIMEOUT  : stalled memory cycles tolerated before ERROR (>= 2)
// Ports
//   clk_i, rst_i            : clock, synchronous active-low reset
//   start_i                 : run enable
//   id_rs_i, id_rt_i        : ID-stage source registers
//   id_uses_rt_i            : ID instruction actually reads rt
//   ex_memread_i, ex_rt_i   : EX-stage load and its destination
//   id_branch_taken_i       : taken branch resolved in ID
//   id_jump_i               : jump decoded in ID
//   mem_req_i, dmem_ack_i   : MEM-stage access and its completion
//   pc_write_o, ifid_write_o: PC / IF-ID write enables
//   ifid_flush_o            : clear IF/ID on the next edge
//   idex_bubble_o           : insert a NOP into ID/EX
//   pipe_en_o               : write enable of ID/EX, EX/MEM, MEM/WB
//   dmem_req_o              : data-memory request
//   err_o                   : sticky memory-timeout flag
//   cycle_cnt_o, stall_cnt_o, flush_cnt_o : performance counters
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             id_branch_taken_i,
    input  logic             id_jump_i,
    input  logic             mem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_en_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Wait counter must be able to hold TIMEOUT-1.
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    // Value held during the last tolerated stall cycle: the stall cycle
    // numbered TIMEOUT sees wait_q == TIMEOUT-1 because the RUN entry
    // cycle is stall cycle 1 and loads the counter with 1.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam int NUM_CNT  = 3;
    localparam int CNT_CYC  = 0;
    localparam int CNT_STL  = 1;
    localparam int CNT_FLS  = 2;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;

    logic active;
    logic mem_stall;
    logic load_use;
    logic redirect;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_en;
    logic dmem_req;

    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    // ------------------------------------------------------------------
    // Hazard detection (independent of state; gated by 'active' below)
    // ------------------------------------------------------------------
    assign active    = state_active(state_q);
    assign mem_stall = mem_req_i & ~dmem_ack_i;
    assign load_use  = ex_memread_i
                     & (ex_rt_i != REG_ZERO)
                     & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    assign redirect  = id_branch_taken_i | id_jump_i;

    // ------------------------------------------------------------------
    // Pipeline controls: zero-latency, memory stall > load-use > flush.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        dmem_req    = 1'b0;
        if (active) begin
            dmem_req = mem_req_i;
            if (mem_stall) begin
                // Whole pipeline frozen while data memory is busy.
                pc_write = 1'b0;
            end else if (load_use) begin
                // Hold PC and IF/ID, bubble into EX. A concurrent branch is
                // not flushed: it stays in ID and resolves again next cycle.
                idex_bubble = 1'b1;
                pipe_en     = 1'b1;
            end else if (redirect) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                pipe_en     = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                pipe_en     = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM and memory wait counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_q <= '0;
                    if (start_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (mem_stall) begin
                        // An access already issued is completed even if
                        // start_i drops in the same cycle.
                        state_q <= MEM_WAIT;
                        wait_q  <= WAIT_W'(1);
                    end else if (!start_i) begin
                        state_q <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_q == WAIT_LAST) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            wait_q  <= '0;
                        end else begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end
                    end else begin
                        // Ack (or the request withdrawn) ends the wait.
                        wait_q  <= '0;
                        state_q <= start_i ? RUN : IDLE;
                    end
                end
                ERROR: begin
                    // Only reset leaves ERROR.
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    wait_q  <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------
    assign cnt_inc[CNT_CYC] = active;
    assign cnt_inc[CNT_STL] = active & (mem_stall | load_use);
    assign cnt_inc[CNT_FLS] = ifid_flush;

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_perf
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .inc_i (cnt_inc[gi]),
                .cnt_o (cnt_val[gi])
            );
        end
    endgenerate

    assign cycle_cnt_o   = cnt_val[CNT_CYC];
    assign stall_cnt_o   = cnt_val[CNT_STL];
    assign flush_cnt_o   = cnt_val[CNT_FLS];

    assign pc_write_o    = pc_write;
    assign ifid_write_o  = ifid_write;
    assign ifid_flush_o  = ifid_flush;
    assign idex_bubble_o = idex_bubble;
    assign pipe_en_o     = pipe_en;
    assign dmem_req_o    = dmem_req;
    assign err_o         = err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed stimulus for pipeline_ctrl. A cycle-level behavioural model tracks
// the controller mode, the length of the current memory wait and the three
// counters; one compare process checks every output against it on each
// falling edge. Literal expectations in the stimulus pin the model.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int     CNT_W   = 32;
    localparam int     TIMEOUT = 16;
    localparam longint CAP     = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             id_branch_taken_i;
    logic             id_jump_i;
    logic             mem_req_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_en_o;
    logic             dmem_req_o;
    logic             err_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    int tests = 0;
    int fails = 0;

    pipeline_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .id_rs_i           (id_rs_i),
        .id_rt_i           (id_rt_i),
        .id_uses_rt_i      (id_uses_rt_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rt_i           (ex_rt_i),
        .id_branch_taken_i (id_branch_taken_i),
        .id_jump_i         (id_jump_i),
        .mem_req_i         (mem_req_i),
        .dmem_ack_i        (dmem_ack_i),
        .pc_write_o        (pc_write_o),
        .ifid_write_o      (ifid_write_o),
        .ifid_flush_o      (ifid_flush_o),
        .idex_bubble_o     (idex_bubble_o),
        .pipe_en_o         (pipe_en_o),
        .dmem_req_o        (dmem_req_o),
        .err_o             (err_o),
        .cycle_cnt_o       (cycle_cnt_o),
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. mode: 0 halted, 1 running, 2 waiting on memory,
    // 3 trapped. 'stalled' = memory stall cycles seen in the current
    // access so far (the first one happens while still running).
    // ------------------------------------------------------------------
    bit     m_valid = 1'b0;
    int     m_mode;
    int     m_stalled;
    longint m_cyc, m_stl, m_fls;

    always @(negedge clk) begin : compare
        bit moving, mstall, hazard, redir;
        bit e_pc, e_ifw, e_fl, e_bub, e_pipe, e_req;
        moving = (m_mode == 1) || (m_mode == 2);
        mstall = mem_req_i && !dmem_ack_i;
        hazard = ex_memread_i && (ex_rt_i != 5'd0) &&
                 ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
        redir  = id_branch_taken_i || id_jump_i;

        e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_pipe = 0; e_req = 0;
        if (moving) begin
            e_req = mem_req_i;
            if (!mstall) begin
                e_pipe = 1;
                e_pc   = !hazard;
                e_ifw  = !hazard;
                e_bub  = hazard;
                e_fl   = !hazard && redir;
            end
        end

        if (m_valid) begin
            chk("pc_write",    pc_write_o,    e_pc);
            chk("ifid_write",  ifid_write_o,  e_ifw);
            chk("ifid_flush",  ifid_flush_o,  e_fl);
            chk("idex_bubble", idex_bubble_o, e_bub);
            chk("pipe_en",     pipe_en_o,     e_pipe);
            chk("dmem_req",    dmem_req_o,    e_req);
            chk("err",         err_o,         m_mode == 3);
            chk("cycle_cnt",   cycle_cnt_o,   m_cyc);
            chk("stall_cnt",   stall_cnt_o,   m_stl);
            chk("flush_cnt",   flush_cnt_o,   m_fls);
        end

        // Advance the model to what the next rising edge produces.
        if (!rst_i) begin
            m_valid = 1'b1;
            m_mode = 0; m_stalled = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0;
        end else if (m_valid) begin
            if (moving) begin
                if (m_cyc < CAP) m_cyc++;
                if ((mstall || hazard) && m_stl < CAP) m_stl++;
                if (e_fl && m_fls < CAP) m_fls++;
            end
            case (m_mode)
                0: if (start_i) m_mode = 1;
                1: begin
                    if (mstall) begin m_mode = 2; m_stalled = 1; end
                    else if (!start_i) m_mode = 0;
                end
                2: begin
                    if (mstall) begin
                        m_stalled++;
                        if (m_stalled >= TIMEOUT) m_mode = 3;
                    end else begin
                        m_stalled = 0;
                        m_mode = start_i ? 1 : 0;
                    end
                end
                default: m_mode = 3;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change 1 time unit after a rising edge;
    // literal checks sample one more unit later.
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_hazards();
        id_rs_i = 0; id_rt_i = 0; id_uses_rt_i = 0;
        ex_memread_i = 0; ex_rt_i = 0;
        id_branch_taken_i = 0; id_jump_i = 0;
        mem_req_i = 0; dmem_ack_i = 0;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0;
        clear_hazards();

        // Reset.
        next_cycle(); next_cycle(); settle();
        $display("[TB] reset");
        chk("rst_cycle_cnt", cycle_cnt_o, 0);
        chk("rst_err",       err_o,       0);
        chk("rst_pc_write",  pc_write_o,  0);

        // Start: IDLE this cycle, RUN next.
        rst_i = 1'b1; start_i = 1'b1; settle();
        chk("start_still_idle", pipe_en_o, 0);
        next_cycle(); settle();
        chk("run_pipe_en",  pipe_en_o,  1);
        chk("run_pc_write", pc_write_o, 1);
        repeat (10) next_cycle();
        settle();
        $display("[TB] run 10 cycles: cycle_cnt=%0d", cycle_cnt_o);
        chk("run10_cycle_cnt", cycle_cnt_o, 10);
        chk("run10_stall_cnt", stall_cnt_o, 0);
        chk("run10_flush_cnt", flush_cnt_o, 0);

        // Load-use on rs with a simultaneous taken branch.
        ex_memread_i = 1; ex_rt_i = 8; id_rs_i = 8; id_branch_taken_i = 1; settle();
        $display("[TB] load-use rs=8 with branch");
        chk("lu_pc_write",   pc_write_o,    0);
        chk("lu_ifid_write", ifid_write_o,  0);
        chk("lu_bubble",     idex_bubble_o, 1);
        chk("lu_flush",      ifid_flush_o,  0);
        next_cycle(); clear_hazards();
        ex_memread_i = 1; ex_rt_i = 0; id_rs_i = 0; settle();
        $display("[TB] load into $zero");
        chk("lu_stall_cnt",  stall_cnt_o,   1);
        chk("zero_bubble",   idex_bubble_o, 0);
        chk("zero_pc_write", pc_write_o,    1);
        next_cycle(); clear_hazards();
        // Load-use through rt, then the same registers with rt unused.
        ex_memread_i = 1; ex_rt_i = 5; id_rt_i = 5; id_rs_i = 3; id_uses_rt_i = 1; settle();
        $display("[TB] load-use rt=5");
        chk("zero_stall_cnt", stall_cnt_o,   1);
        chk("rt_bubble",      idex_bubble_o, 1);
        next_cycle(); id_uses_rt_i = 0; settle();
        chk("rt_unused_bubble", idex_bubble_o, 0);
        next_cycle(); clear_hazards(); settle();
        chk("rt_stall_cnt", stall_cnt_o, 2);

        // Jump alone.
        id_jump_i = 1; settle();
        $display("[TB] jump");
        chk("jmp_flush",    ifid_flush_o, 1);
        chk("jmp_pc_write", pc_write_o,   1);
        next_cycle(); id_jump_i = 0; settle();
        chk("jmp_flush_off", ifid_flush_o, 0);
        chk("jmp_flush_cnt", flush_cnt_o,  1);

        // Memory access acknowledged in the fourth cycle.
        mem_req_i = 1; dmem_ack_i = 0; settle();
        $display("[TB] mem wait 3 cycles");
        chk("mw_c1_pipe", pipe_en_o,  0);
        chk("mw_c1_req",  dmem_req_o, 1);
        next_cycle(); settle(); chk("mw_c2_pipe", pipe_en_o, 0);
        next_cycle(); settle(); chk("mw_c3_pipe", pipe_en_o, 0);
        next_cycle(); dmem_ack_i = 1; settle(); chk("mw_ack_pipe", pipe_en_o, 1);
        next_cycle(); clear_hazards(); settle();
        chk("mw_stall_cnt", stall_cnt_o, 5);
        chk("mw_back_run",  pipe_en_o,   1);

        // Ack coinciding with a load-use hazard.
        mem_req_i = 1; settle();
        next_cycle(); dmem_ack_i = 1; ex_memread_i = 1; ex_rt_i = 8; id_rs_i = 8; settle();
        $display("[TB] ack with load-use");
        chk("ackLU_bubble", idex_bubble_o, 1);
        chk("ackLU_pc",     pc_write_o,    0);
        next_cycle(); clear_hazards(); settle();
        chk("ackLU_stall_cnt", stall_cnt_o, 7);

        // start_i dropped during a memory wait.
        mem_req_i = 1; settle();
        next_cycle(); start_i = 0; settle();
        $display("[TB] start dropped mid-wait");
        chk("drop_c2_pipe", pipe_en_o,  0);
        chk("drop_c2_req",  dmem_req_o, 1);
        next_cycle(); settle(); chk("drop_c3_pipe", pipe_en_o, 0);
        next_cycle(); dmem_ack_i = 1; settle(); chk("drop_ack_pipe", pipe_en_o, 1);
        next_cycle(); clear_hazards(); settle();
        chk("drop_idle_pc",   pc_write_o, 0);
        chk("drop_idle_pipe", pipe_en_o,  0);

        // Ack in waited cycle TIMEOUT succeeds.
        start_i = 1;
        next_cycle(); mem_req_i = 1; settle();
        $display("[TB] ack on last tolerated cycle");
        for (int k = 2; k <= TIMEOUT; k++) next_cycle();
        dmem_ack_i = 1; settle();
        chk("late_ack_pipe", pipe_en_o, 1);
        next_cycle(); clear_hazards(); settle();
        chk("late_ack_err",  err_o,     0);
        chk("late_ack_run",  pipe_en_o, 1);

        // No ack: ERROR on cycle TIMEOUT+1.
        mem_req_i = 1; settle();
        $display("[TB] memory timeout");
        for (int k = 2; k <= TIMEOUT; k++) next_cycle();
        settle();
        chk("to_c16_err", err_o, 0);
        next_cycle(); settle();
        chk("to_c17_err",  err_o,      1);
        chk("to_c17_pipe", pipe_en_o,  0);
        chk("to_c17_req",  dmem_req_o, 0);
        repeat (3) next_cycle();
        settle();
        chk("to_sticky_err", err_o, 1);

        // Reset clears everything.
        rst_i = 0; mem_req_i = 0;
        next_cycle(); settle();
        $display("[TB] reset from ERROR");
        chk("rst2_err",       err_o,       0);
        chk("rst2_cycle_cnt", cycle_cnt_o, 0);
        chk("rst2_stall_cnt", stall_cnt_o, 0);
        chk("rst2_flush_cnt", flush_cnt_o, 0);
        rst_i = 1; start_i = 0;
        next_cycle(); next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencing and hazard controller for the 5-stage MIPS CPU. It resolves load-use stalls, branch/jump flushes and data-memory wait states into per-stage write/flush/bubble controls, and arbitrates their priority. It gates the whole pipeline on `start_i`, detects hung memory transactions, and keeps saturating cycle, stall and flush performance counters for the bench.

## Interface
- `CNT_W`, 32: width of each performance counter.
- `TIMEOUT`, 16: maximum number of un-acknowledged data-memory request cycles before the error state (≥2).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: run enable from the CPU top.
- `id_rs_i`, `id_rt_i` in 5: source registers of the instruction in ID.
- `id_uses_rt_i` in 1: the ID instruction reads rt.
- `ex_memread_i` in 1: the EX instruction is a load.
- `ex_rt_i` in 5: destination of the EX load.
- `id_branch_taken_i` in 1: branch resolved taken in ID.
- `id_jump_i` in 1: jump decoded in ID.
- `mem_req_i` in 1: the MEM-stage instruction accesses data memory.
- `dmem_ack_i` in 1: data memory completes the access this cycle.
- `pc_write_o`, `ifid_write_o` out 1: PC and IF/ID register write enables.
- `ifid_flush_o` out 1: zero IF/ID on the next edge.
- `idex_bubble_o` out 1: load a NOP into ID/EX.
- `pipe_en_o` out 1: write enable for ID/EX, EX/MEM and MEM/WB.
- `dmem_req_o` out 1: data-memory request.
- `err_o` out 1: memory timeout, sticky.
- `cycle_cnt_o`, `stall_cnt_o`, `flush_cnt_o` out CNT_W: performance counters.

## Operation
**States**
- IDLE, RUN, MEM_WAIT, ERROR.
- Reset state is IDLE.

**Transitions**
- IDLE→RUN when `start_i`=1.
- RUN→IDLE when `start_i`=0.
- RUN→MEM_WAIT when `mem_req_i`=1 and `dmem_ack_i`=0.
- MEM_WAIT→RUN, or →IDLE if `start_i`=0, on `dmem_ack_i`. An in-flight access is never abandoned on `start_i` low.
- MEM_WAIT→ERROR when the waited-cycle count reaches `TIMEOUT` without an ack.
- ERROR is sticky; only reset exits it.

**Outputs in IDLE and ERROR**
- All enables, flush, bubble and `dmem_req_o` are 0.
- `err_o`=1 in ERROR only.

**Outputs in RUN and MEM_WAIT**, combinational. Priority is memory stall, then load-use stall, then flush.
- `dmem_req_o` = `mem_req_i`.
- Memory stall = `mem_req_i` & !`dmem_ack_i`. It forces every enable, flush and bubble to 0.
- Load-use hazard = `ex_memread_i` & `ex_rt_i`≠0 & (`ex_rt_i`==`id_rs_i` | (`id_uses_rt_i` & `ex_rt_i`==`id_rt_i`)).
- Load-use stall (no memory stall): `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1, `pipe_en_o`=1. Any flush is suppressed; the branch is re-evaluated on the next cycle.
- Flush = (`id_branch_taken_i` | `id_jump_i`) with no stall: `ifid_flush_o`=1, `pc_write_o`=1, `pipe_en_o`=1.
- Otherwise all write enables are 1, and flush and bubble are 0.

**Counters**
- All three reset to 0 and saturate at 2^CNT_W−1.
- `cycle_cnt_o`: +1 every cycle in RUN or MEM_WAIT.
- `stall_cnt_o`: +1 per memory-stall or load-use-stall cycle, counted once per cycle.
- `flush_cnt_o`: +1 per cycle with `ifid_flush_o`=1.
- Counters hold in IDLE and ERROR.

**Wait counter**
- Counts consecutive cycles with a memory stall; the RUN entry cycle counts as 1.
- Cleared on ack and on leaving MEM_WAIT.

## Timing
- Control outputs are combinational from the registered state and the current inputs, with zero-cycle latency.
- State, counters and `err_o` update on the rising edge.
- During reset (`rst_i`=0 at the edge), the following cycle shows the IDLE outputs: all 0, counters 0, `err_o` 0.
- A reset asserted mid-MEM_WAIT or in ERROR takes effect at that edge.
- Timeout: an ack in waited cycle `TIMEOUT` succeeds. With no ack by then, ERROR is visible on cycle `TIMEOUT`+1.
- `start_i` rising: first RUN cycle is the next cycle.
- `start_i` falling in RUN: IDLE is visible next cycle. The current cycle's outputs are still RUN outputs.
- A memory ack in the same cycle as a load-use hazard: the load-use rule applies that cycle.

## Structure
- Package `pipeline_ctrl_pkg` holds the state enum (IDLE/RUN/MEM_WAIT/ERROR), `REG_ZERO`=5'd0 and the default `CNT_W`.
- Sub-module `sat_counter` (parameter `W`; ports `clk_i`, `rst_i`, `inc_i`, `cnt_o`) is instantiated three times for the performance counters.
- Hazard detection, FSM and wait counter stay in `pipeline_ctrl`.

## Test plan
- Reset then `start_i`=1 with no hazards for 10 cycles → all enables 1; `cycle_cnt_o`=10, `stall_cnt_o`=0, `flush_cnt_o`=0.
- Load-use: `ex_memread_i`=1, `ex_rt_i`=8, `id_rs_i`=8, with `id_branch_taken_i`=1 in the same cycle → `pc_write_o`=0, `ifid_write_o`=0, `idex_bubble_o`=1, `ifid_flush_o`=0; `stall_cnt_o` +1. Repeat with `ex_rt_i`=0 → no stall.
- Jump alone → `ifid_flush_o`=1 for 1 cycle; `flush_cnt_o` +1.
- `mem_req_i`=1 with the ack after 3 cycles → `pipe_en_o`=0 for 3 cycles and 1 in the ack cycle; `stall_cnt_o` +3; state returns to RUN.
- `mem_req_i` held with no ack → ERROR visible on cycle 17 (`TIMEOUT`=16), `err_o`=1, counters frozen; `rst_i`=0 clears everything.
- `start_i` dropped mid-MEM_WAIT → the wait continues until the ack, then IDLE, all enables 0.
